// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants, encodings and helpers for the 7-segment capture path
package sevenseg_pkg;

  // Active-low cathode patterns, bit7 = DP (off), bits6:0 = g..a
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [7:0] ANODE_ONES  = 8'hFE;
  localparam logic [7:0] ANODE_TENS  = 8'hFD;
  localparam logic [7:0] ANODE_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_HAVE_ONES = 2'd1,
    ST_HAVE_TENS = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    POS_BLANK   = 2'd0,
    POS_ONES    = 2'd1,
    POS_TENS    = 2'd2,
    POS_INVALID = 2'd3
  } pos_t;

  function automatic pos_t anode_pos(input logic [7:0] anode);
    case (anode)
      ANODE_ONES:  return POS_ONES;
      ANODE_TENS:  return POS_TENS;
      ANODE_BLANK: return POS_BLANK;
      default:     return POS_INVALID;
    endcase
  endfunction

  // tens*10 + ones as 8*tens + 2*tens + ones; inputs are BCD so the result fits in 7 bits
  function automatic logic [7:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] sum;
    sum = 7'({tens, 3'b000}) + 7'({tens, 1'b0}) + 7'(ones);
    return {1'b0, sum};
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational cathode pattern to BCD digit decoder
module seg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [7:0] cathode,
  output logic [3:0] digit,
  output logic       digit_ok
);

  always_comb begin
    digit    = 4'd0;
    digit_ok = 1'b1;
    case (cathode)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: digit_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - samples the scanned display bus and rebuilds the two-digit value
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 64,
  parameter int CNT_W         = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] anode,
  input  logic [7:0] cathode,
  output logic [7:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       valid,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 1);

  logic [15:0]      sync1, sync2, last_word;
  logic [CNT_W-1:0] stab_cnt;
  logic             same, accept;
  pos_t             pos;
  logic [3:0]       digit;
  logic             digit_ok;
  state_t           state;
  logic [3:0]       ones_q, tens_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 16'hFFFF;
      sync2     <= 16'hFFFF;
      last_word <= 16'hFFFF;
    end else begin
      sync1     <= {anode, cathode};
      sync2     <= sync1;
      last_word <= sync2;
    end
  end

  assign same = (sync2 == last_word);

  // Saturating at STABLE_CYCLES keeps a long stable phase from accepting twice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
    end else if (!same) begin
      stab_cnt <= '0;
    end else if (stab_cnt != CNT_MAX) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign accept = same && (stab_cnt == CNT_ACCEPT);
  assign pos    = anode_pos(sync2[15:8]);

  seg_pattern_decode u_decode (
    .cathode  (sync2[7:0]),
    .digit    (digit),
    .digit_ok (digit_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      value  <= 8'd0;
      tens   <= 4'd0;
      ones   <= 4'd0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (accept && pos != POS_BLANK) begin
        if (pos == POS_INVALID || !digit_ok) begin
          err   <= 1'b1;
          state <= ST_EMPTY;
        end else begin
          case (state)
            ST_EMPTY: begin
              if (pos == POS_ONES) begin
                ones_q <= digit;
                state  <= ST_HAVE_ONES;
              end else begin
                tens_q <= digit;
                state  <= ST_HAVE_TENS;
              end
            end
            ST_HAVE_ONES: begin
              if (pos == POS_ONES) begin
                ones_q <= digit;
              end else begin
                tens  <= digit;
                ones  <= ones_q;
                value <= bcd_to_bin(digit, ones_q);
                valid <= 1'b1;
                state <= ST_EMPTY;
              end
            end
            ST_HAVE_TENS: begin
              if (pos == POS_TENS) begin
                tens_q <= digit;
              end else begin
                tens  <= tens_q;
                ones  <= digit;
                value <= bcd_to_bin(tens_q, digit);
                valid <= 1'b1;
                state <= ST_EMPTY;
              end
            end
            default: state <= ST_EMPTY;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - randomized self-checking bench for sevenseg_capture
module tb_sevenseg_capture;

  localparam int STABLE_CYCLES = 64;
  localparam int LATENCY       = 2 + STABLE_CYCLES + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] anode = 8'hFF;
  logic [7:0] cathode = 8'hFF;
  logic [7:0] value;
  logic [3:0] tens, ones;
  logic       valid, err;

  int n_checks = 0;
  int n_fail   = 0;

  int pend_ones = -1;
  int pend_tens = -1;
  int last_val  = 0;
  int last_tens = 0;
  int last_ones = 0;
  logic [15:0] prev_word = 16'hFFFF;

  byte unsigned seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  sevenseg_capture #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .anode   (anode),
    .cathode (cathode),
    .value   (value),
    .tens    (tens),
    .ones    (ones),
    .valid   (valid),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int seg_digit(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (c == seg_tab[i]) return i;
    return -1;
  endfunction

  // Hold one bus pattern for 'hold' cycles; the model decides what the display
  // receiver should have concluded from it and the observed pulses are compared.
  task automatic run_phase(input logic [7:0] a, input logic [7:0] c, input int hold, input string tag);
    int d, exp_valid, exp_err, exp_t, exp_o, nv, ne, both, lat, got_v, got_t, got_o;
    exp_valid = 0; exp_err = 0; exp_t = 0; exp_o = 0;
    if (hold >= STABLE_CYCLES + 4 && a != 8'hFF) begin
      d = seg_digit(c);
      if ((a != 8'hFE && a != 8'hFD) || d < 0) begin
        exp_err = 1; pend_ones = -1; pend_tens = -1;
      end else if (a == 8'hFE) begin
        if (pend_tens >= 0) begin
          exp_valid = 1; exp_t = pend_tens; exp_o = d; pend_ones = -1; pend_tens = -1;
        end else pend_ones = d;
      end else begin
        if (pend_ones >= 0) begin
          exp_valid = 1; exp_t = d; exp_o = pend_ones; pend_ones = -1; pend_tens = -1;
        end else pend_tens = d;
      end
    end
    anode = a; cathode = c; prev_word = {a, c};
    nv = 0; ne = 0; both = 0; lat = 0; got_v = 0; got_t = 0; got_o = 0;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      if (valid) begin nv++; lat = i; got_v = value; got_t = tens; got_o = ones; end
      if (err) ne++;
      if (valid && err) both++;
    end
    check({tag, " valid_count"}, nv, exp_valid);
    check({tag, " err_count"}, ne, exp_err);
    check({tag, " valid_err_overlap"}, both, 0);
    if (exp_valid) begin
      last_tens = exp_t; last_ones = exp_o; last_val = exp_t * 10 + exp_o;
      check({tag, " value"}, got_v, last_val);
      check({tag, " tens"}, got_t, exp_t);
      check({tag, " ones"}, got_o, exp_o);
      check({tag, " latency"}, lat, LATENCY);
    end
    check({tag, " held_value"}, value, last_val);
    check({tag, " held_digits"}, {tens, ones}, {last_tens[3:0], last_ones[3:0]});
  endtask

  task automatic pulse_reset();
    anode = 8'hFF; cathode = 8'hFF; prev_word = 16'hFFFF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {value, tens, ones, valid, err}, 0);
    rst_n = 1'b1;
    pend_ones = -1; pend_tens = -1;
    last_val = 0; last_tens = 0; last_ones = 0;
  endtask

  initial begin
    logic [7:0] a, c;
    int hold, sel;

    // Reset held low while the buses toggle
    for (int i = 0; i < 20; i++) begin
      anode = 8'($urandom); cathode = 8'($urandom);
      @(negedge clk);
      check("reset_hold", {value, tens, ones, valid, err}, 0);
    end
    anode = 8'hFF; cathode = 8'hFF;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_phase(8'hFE, 8'h92, 100, "ones5");
    run_phase(8'hFD, 8'hA4, 100, "tens2");

    run_phase(8'hFD, 8'h99, 100, "tens4");
    run_phase(8'hFE, 8'hB0, 100, "ones3");
    run_phase(8'hFE, 8'hF8, 100, "ones7");
    run_phase(8'hFD, 8'hF9, 100, "tens1");

    run_phase(8'hFE, 8'hC0, STABLE_CYCLES - 2, "glitch");
    run_phase(8'hFF, 8'hFF, 20, "glitch_after");

    run_phase(8'hFE, 8'h00, 100, "bad_cathode");
    run_phase(8'hFC, 8'hC0, 100, "bad_anode");
    run_phase(8'hFF, 8'h12, 100, "blank_any");

    run_phase(8'hFE, 8'h92, 100, "pre_reset_ones");
    pulse_reset();
    run_phase(8'hFD, 8'hA4, 100, "post_reset_tens");
    run_phase(8'hFE, 8'hC0, 100, "post_reset_ones");

    for (int n = 0; n < 40; n++) begin
      do begin
        sel = $urandom_range(0, 9);
        a = (sel < 4) ? 8'hFE : (sel < 8) ? 8'hFD : (sel == 8) ? 8'hFF : 8'($urandom);
        c = ($urandom_range(0, 7) != 0) ? seg_tab[$urandom_range(0, 9)] : 8'($urandom);
      end while ({a, c} == prev_word);
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, STABLE_CYCLES - 2)
                                         : STABLE_CYCLES + 8 + $urandom_range(0, 8);
      run_phase(a, c, hold, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
